// File: rtl/mvm_partial_reducer.sv
// mvm_partial_reducer: buffers two MVM partial-result streams in FIFOs and emits
// their lane-wise (optionally saturating) signed sum through one output register.
module mvm_partial_reducer #(
    parameter int DATAW      = 32,
    parameter int OPRECISION = 8,
    parameter int LANES      = 4,
    parameter int DESTW      = 6,
    parameter int USERW      = 32,
    parameter int FIFOD      = 8,
    parameter int SATURATE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_tvalid,
    input  logic             s1_tvalid,
    output logic             s0_tready,
    output logic             s1_tready,
    input  logic [DATAW-1:0] s0_tdata,
    input  logic [DATAW-1:0] s1_tdata,
    input  logic             s0_tlast,
    input  logic             s1_tlast,
    input  logic [DESTW-1:0] s0_tdest,
    input  logic [USERW-1:0] s0_tuser,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [DATAW-1:0] m_tdata,
    output logic             m_tlast,
    output logic [DESTW-1:0] m_tdest,
    output logic [USERW-1:0] m_tuser,
    output logic             err_last_mismatch,
    output logic [15:0]      vec_count
);
    localparam int AW  = $clog2(FIFOD);
    localparam int E0W = DATAW + 1 + DESTW + USERW;

    logic [E0W-1:0]   mem0_q [FIFOD];
    logic [DATAW:0]   mem1_q [FIFOD];
    logic [AW:0]      wp0_q, rp0_q, wp1_q, rp1_q;
    logic             full0, full1, empty0, empty1, push0, push1, pop;
    logic [E0W-1:0]   head0;
    logic [DATAW:0]   head1;
    logic [DATAW-1:0] sum_d;

    logic             m_tvalid_q, m_tvalid_d, m_tlast_q, err_q, err_d;
    logic [DATAW-1:0] m_tdata_q;
    logic [DESTW-1:0] m_tdest_q;
    logic [USERW-1:0] m_tuser_q;
    logic [15:0]      vec_q, vec_d;

    // The extra MSB on each pointer separates full from empty when the indices match.
    assign full0  = (wp0_q[AW] != rp0_q[AW]) && (wp0_q[AW-1:0] == rp0_q[AW-1:0]);
    assign full1  = (wp1_q[AW] != rp1_q[AW]) && (wp1_q[AW-1:0] == rp1_q[AW-1:0]);
    assign empty0 = wp0_q == rp0_q;
    assign empty1 = wp1_q == rp1_q;

    assign s0_tready = !full0 && !rst;
    assign s1_tready = !full1 && !rst;
    assign push0     = s0_tvalid && s0_tready;
    assign push1     = s1_tvalid && s1_tready;
    assign pop       = !empty0 && !empty1 && (!m_tvalid_q || m_tready);

    assign head0 = mem0_q[rp0_q[AW-1:0]];
    assign head1 = mem1_q[rp1_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push0) mem0_q[wp0_q[AW-1:0]] <= {s0_tuser, s0_tdest, s0_tlast, s0_tdata};
        if (push1) mem1_q[wp1_q[AW-1:0]] <= {s1_tlast, s1_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp0_q <= '0;
            rp0_q <= '0;
            wp1_q <= '0;
            rp1_q <= '0;
        end else begin
            wp0_q <= wp0_q + {{AW{1'b0}}, push0};
            wp1_q <= wp1_q + {{AW{1'b0}}, push1};
            rp0_q <= rp0_q + {{AW{1'b0}}, pop};
            rp1_q <= rp1_q + {{AW{1'b0}}, pop};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [OPRECISION-1:0] a, b;
        logic [OPRECISION:0]   s;
        logic                  ovf;
        assign a   = head0[i*OPRECISION +: OPRECISION];
        assign b   = head1[i*OPRECISION +: OPRECISION];
        assign s   = {a[OPRECISION-1], a} + {b[OPRECISION-1], b};
        assign ovf = s[OPRECISION] ^ s[OPRECISION-1];
        assign sum_d[i*OPRECISION +: OPRECISION] = (SATURATE != 0 && ovf) ?
            (s[OPRECISION] ? {1'b1, {(OPRECISION-1){1'b0}}} : {1'b0, {(OPRECISION-1){1'b1}}}) :
            s[OPRECISION-1:0];
    end

    always_comb begin
        m_tvalid_d = pop ? 1'b1 : (m_tready ? 1'b0 : m_tvalid_q);
        err_d      = err_q || (pop && (head0[DATAW] != head1[DATAW]));
        vec_d      = vec_q + {15'd0, m_tvalid_q && m_tready && m_tlast_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tdest_q  <= '0;
            m_tuser_q  <= '0;
            err_q      <= 1'b0;
            vec_q      <= '0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            err_q      <= err_d;
            vec_q      <= vec_d;
            if (pop) begin
                m_tdata_q <= sum_d;
                m_tlast_q <= head0[DATAW];
                m_tdest_q <= head0[DATAW+1 +: DESTW];
                m_tuser_q <= head0[DATAW+1+DESTW +: USERW];
            end
        end
    end

    assign m_tvalid          = m_tvalid_q;
    assign m_tdata           = m_tdata_q;
    assign m_tlast           = m_tlast_q;
    assign m_tdest           = m_tdest_q;
    assign m_tuser           = m_tuser_q;
    assign err_last_mismatch = err_q;
    assign vec_count         = vec_q;
endmodule

// File: tb/tb_mvm_partial_reducer.sv
// tb_mvm_partial_reducer: directed checks of the reducer; a saturating and a
// wrapping instance share the same stimulus.
module tb_mvm_partial_reducer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic [31:0] s0_tdata = '0, s1_tdata = '0, s0_tuser = '0;
    logic [5:0]  s0_tdest = '0;
    logic        m_tready = 1'b0;
    logic        s0_tready, s1_tready, m_tvalid, m_tlast, err_last_mismatch;
    logic [31:0] m_tdata, m_tuser;
    logic [5:0]  m_tdest;
    logic [15:0] vec_count;
    logic        w_s0_tready, w_s1_tready, w_tvalid, w_tlast, w_err;
    logic [31:0] w_tdata, w_tuser;
    logic [5:0]  w_tdest;
    logic [15:0] w_vec;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mvm_partial_reducer #(.SATURATE(1)) dut (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s1_tvalid(s1_tvalid), .s0_tready(s0_tready), .s1_tready(s1_tready),
        .s0_tdata(s0_tdata), .s1_tdata(s1_tdata), .s0_tlast(s0_tlast), .s1_tlast(s1_tlast),
        .s0_tdest(s0_tdest), .s0_tuser(s0_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tdest(m_tdest), .m_tuser(m_tuser), .err_last_mismatch(err_last_mismatch), .vec_count(vec_count)
    );

    mvm_partial_reducer #(.SATURATE(0)) dut_w (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s1_tvalid(s1_tvalid), .s0_tready(w_s0_tready), .s1_tready(w_s1_tready),
        .s0_tdata(s0_tdata), .s1_tdata(s1_tdata), .s0_tlast(s0_tlast), .s1_tlast(s1_tlast),
        .s0_tdest(s0_tdest), .s0_tuser(s0_tuser),
        .m_tvalid(w_tvalid), .m_tready(m_tready), .m_tdata(w_tdata), .m_tlast(w_tlast),
        .m_tdest(w_tdest), .m_tuser(w_tuser), .err_last_mismatch(w_err), .vec_count(w_vec)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [31:0] d0, input logic l0, input logic [31:0] d1, input logic l1);
        s0_tvalid = 1'b1; s0_tdata = d0; s0_tlast = l0;
        s1_tvalid = 1'b1; s1_tdata = d1; s1_tlast = l1;
    endtask

    task automatic idle;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b%b want 00", s0_tready, s1_tready); end
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || vec_count !== 16'h0 || err_last_mismatch !== 1'b0) begin errors++; $display("FAIL reset_outputs: valid=%b data=%h vec=%0d err=%b want all 0", m_tvalid, m_tdata, vec_count, err_last_mismatch); end
        rst = 1'b0;
        #1;
        checks++; if (s0_tready !== 1'b1 || s1_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b%b want 11", s0_tready, s1_tready); end
    endtask

    task automatic test_basic;
        m_tready = 1'b1;
        s0_tdest = 6'd5; s0_tuser = 32'hABCD_1234;
        drive_pair(32'h01020304, 1'b1, 32'h10203040, 1'b1);
        tick;
        idle;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid=%b want 0", m_tvalid); end
        tick;
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", m_tvalid); end
        checks++; if (m_tdata !== 32'h11223344) begin errors++; $display("FAIL basic_data: got %h want 11223344", m_tdata); end
        checks++; if (m_tlast !== 1'b1 || m_tdest !== 6'd5 || m_tuser !== 32'hABCD_1234) begin errors++; $display("FAIL basic_sideband: last=%b dest=%0d user=%h want 1 5 abcd1234", m_tlast, m_tdest, m_tuser); end
        tick;
        checks++; if (vec_count !== 16'd1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_vec: vec=%0d valid=%b want 1 0", vec_count, m_tvalid); end
    endtask

    task automatic test_saturate;
        logic [31:0] in0 [3];
        logic [31:0] in1 [3];
        logic [31:0] exp_s [3];
        logic [31:0] exp_w [3];
        in0 = '{32'h7F7F7F7F, 32'h80808080, 32'h7F00807F};
        in1 = '{32'h01010101, 32'hFFFFFFFF, 32'h017F80FF};
        exp_s = '{32'h7F7F7F7F, 32'h80808080, 32'h7F7F807E};
        exp_w = '{32'h80808080, 32'h7F7F7F7F, 32'h807F007E};
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_pair(in0[k], 1'b0, in1[k], 1'b0);
            tick;
            if (k > 0) begin
                checks++; if (m_tdata !== exp_s[k-1] || w_tdata !== exp_w[k-1]) begin errors++; $display("FAIL sat_word%0d: sat=%h wrap=%h want %h %h", k-1, m_tdata, w_tdata, exp_s[k-1], exp_w[k-1]); end
            end
        end
        idle;
        tick;
        checks++; if (m_tdata !== exp_s[2] || w_tdata !== exp_w[2]) begin errors++; $display("FAIL sat_word2: sat=%h wrap=%h want %h %h", m_tdata, w_tdata, exp_s[2], exp_w[2]); end
        tick;
    endtask

    task automatic test_skew_backpressure;
        logic [15:0] vec0;
        vec0 = vec_count;
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s0_tvalid = 1'b1; s0_tdata = {4{8'(i + 1)}}; s0_tlast = (i == 7);
            tick;
        end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL skew_full: s0_tready=%b want 0", s0_tready); end
        s0_tdata = 32'hDEADBEEF;
        tick;
        s0_tvalid = 1'b0;
        checks++; if (m_tvalid !== 1'b0 || s0_tready !== 1'b0) begin errors++; $display("FAIL skew_no_output: valid=%b s0_tready=%b want 0 0", m_tvalid, s0_tready); end
        for (int j = 0; j < 8; j++) begin
            s1_tvalid = 1'b1; s1_tdata = {4{8'(16 * (j + 1))}}; s1_tlast = (j == 7);
            tick;
        end
        idle;
        for (int h = 0; h < 3; h++) begin
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h11111111 || m_tlast !== 1'b0) begin errors++; $display("FAIL skew_hold%0d: valid=%b data=%h last=%b want 1 11111111 0", h, m_tvalid, m_tdata, m_tlast); end
            tick;
        end
        m_tready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick;
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== {4{8'(17 * (k + 1))}}) begin errors++; $display("FAIL skew_drain%0d: valid=%b data=%h want 1 %h", k, m_tvalid, m_tdata, {4{8'(17 * (k + 1))}}); end
        end
        checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL skew_last: got %b want 1", m_tlast); end
        tick;
        checks++; if (m_tvalid !== 1'b0 || vec_count !== vec0 + 16'd1) begin errors++; $display("FAIL skew_end: valid=%b vec=%0d want 0 %0d", m_tvalid, vec_count, vec0 + 16'd1); end
    endtask

    task automatic test_framing;
        logic [15:0] vec0;
        vec0 = vec_count;
        m_tready = 1'b1;
        checks++; if (err_last_mismatch !== 1'b0) begin errors++; $display("FAIL frame_pre: err=%b want 0", err_last_mismatch); end
        drive_pair(32'h00000001, 1'b1, 32'h00000002, 1'b0);
        tick;
        idle;
        tick;
        checks++; if (err_last_mismatch !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== 32'h00000003) begin errors++; $display("FAIL frame_pop: err=%b last=%b data=%h want 1 1 00000003", err_last_mismatch, m_tlast, m_tdata); end
        tick;
        checks++; if (vec_count !== vec0 + 16'd1) begin errors++; $display("FAIL frame_vec: got %0d want %0d", vec_count, vec0 + 16'd1); end
        drive_pair(32'h00000005, 1'b1, 32'h00000005, 1'b1);
        tick;
        idle;
        tick; tick;
        checks++; if (err_last_mismatch !== 1'b1) begin errors++; $display("FAIL frame_sticky: err=%b want 1", err_last_mismatch); end
    endtask

    task automatic test_reset_mid;
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_pair({4{8'(k + 1)}}, 1'b0, {4{8'(k + 1)}}, 1'b0);
            tick;
        end
        idle;
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_loaded: valid=%b want 1", m_tvalid); end
        rst = 1'b1;
        #1;
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin errors++; $display("FAIL mid_tready: got %b%b want 00", s0_tready, s1_tready); end
        tick;
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_tdest !== 6'h0 || m_tuser !== 32'h0 || err_last_mismatch !== 1'b0 || vec_count !== 16'h0) begin errors++; $display("FAIL mid_cleared: valid=%b data=%h last=%b dest=%h user=%h err=%b vec=%0d want all 0", m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser, err_last_mismatch, vec_count); end
        rst = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: valid=%b want 0", k, m_tvalid); end
        end
        s0_tdest = 6'd9; s0_tuser = 32'h0000_0077;
        drive_pair(32'h05060708, 1'b1, 32'h01010101, 1'b1);
        tick;
        idle;
        tick;
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h06070809 || m_tdest !== 6'd9 || m_tuser !== 32'h77) begin errors++; $display("FAIL mid_new: valid=%b data=%h dest=%0d user=%h want 1 06070809 9 77", m_tvalid, m_tdata, m_tdest, m_tuser); end
        tick;
        checks++; if (vec_count !== 16'd1) begin errors++; $display("FAIL mid_vec: got %0d want 1", vec_count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturate;
        test_skew_backpressure;
        test_framing;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mvm_partial_reducer.md
MVM_PARTIAL_REDUCER -- requirements
Module: mvm_partial_reducer

Interface
REQ-001 SHALL have parameter DATAW, default 32: word width of every data port.
REQ-002 SHALL have parameter OPRECISION, default 8: signed lane width.
REQ-003 SHALL have parameter LANES, default 4: lanes per word; DATAW = LANES*OPRECISION.
REQ-004 SHALL have parameter DESTW, default 6: tdest width.
REQ-005 SHALL have parameter USERW, default 32: tuser width.
REQ-006 SHALL have parameter FIFOD, default 8: per-input FIFO depth; must be a power of 2 and at least 2.
REQ-007 SHALL have parameter SATURATE, default 1: 1 = saturating lane add, 0 = wrapping lane add.
REQ-008 SHALL have ports in this order:
- clk  in  1  sole clock; one clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s0_tvalid / s1_tvalid  in  1  partial-result valid, MVM 0 and MVM 1.
- s0_tready / s1_tready  out  1  input ready.
- s0_tdata / s1_tdata  in  DATAW  LANES packed signed partial sums; lane i at bits [i*OPRECISION +: OPRECISION].
- s0_tlast / s1_tlast  in  1  last word of a vector.
- s0_tdest  in  DESTW  destination, forwarded to output.
- s0_tuser  in  USERW  user tag, forwarded to output.
- m_tvalid  out  1  reduced word valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  DATAW  lane-wise sum.
- m_tlast  out  1  vector end.
- m_tdest  out  DESTW  destination.
- m_tuser  out  USERW  user tag.
- err_last_mismatch  out  1  sticky framing error.
- vec_count  out  16  count of completed output vectors.

Function
REQ-009 SHALL buffer each input in its own FIFOD-entry FIFO. Entry width: s0 = DATAW+1+DESTW+USERW; s1 = DATAW+1.
REQ-010 SHALL drive sN_tready = !fifoN_full && !rst.
REQ-011 Push to FIFO N SHALL occur exactly on an edge where sN_tvalid && sN_tready.
REQ-012 A full FIFO SHALL NOT accept a word on the same edge it pops, even though space frees on that edge.
REQ-013 SHALL have a single output register stage.
REQ-014 Pop both FIFO heads and load the output register together on an edge where both FIFOs are non-empty and (!m_tvalid || m_tready).
REQ-015 SHALL never pop one FIFO without the other.
REQ-016 m_tdata lane i SHALL equal s0 lane i + s1 lane i, computed signed at OPRECISION+1 bits.
REQ-017 With SATURATE=1, the lane sum SHALL clamp to [-2^(OPRECISION-1), 2^(OPRECISION-1)-1]. With SATURATE=0, it SHALL keep the low OPRECISION bits.
REQ-018 Lanes SHALL be independent: no carry between lanes.
REQ-019 m_tdest and m_tuser SHALL come from the s0 head.
REQ-020 m_tlast SHALL equal the s0 head tlast.
REQ-021 If the popped heads have unequal tlast, err_last_mismatch SHALL set on that edge and hold until rst. Data flow continues unchanged.
REQ-022 m_tvalid, m_tdata, m_tlast, m_tdest and m_tuser SHALL stay stable while m_tvalid && !m_tready.
REQ-023 Latency: words pushed into both empty FIFOs on edge k SHALL appear with m_tvalid high after edge k+1.
REQ-024 Throughput SHALL be one word per cycle under continuous valid and ready.
REQ-025 vec_count SHALL increment on each edge with m_tvalid && m_tready && m_tlast, wrapping 65535 -> 0.
REQ-026 FIFO pointers SHALL wrap modulo FIFOD. Full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-027 On an edge with rst=1, both FIFOs SHALL be emptied, discarding any in-flight words, even mid-vector.
REQ-028 On that edge, m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser, err_last_mismatch and vec_count SHALL clear to 0.
REQ-029 While rst=1, s0_tready and s1_tready SHALL be 0.
REQ-030 Normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-031 Basic add: s0 = 0x01020304 and s1 = 0x10203040, both with tlast=1, pushed on edge k, m_tready=1 -> m_tdata = 0x11223344, m_tlast=1, m_tvalid high after edge k+1, vec_count = 1.
REQ-032 Saturation: s0 lanes 0x7F, s1 lanes 0x01; then s0 lanes 0x80, s1 lanes 0xFF.
- SATURATE=1 -> 0x7F7F7F7F, then 0x80808080.
- SATURATE=0 -> 0x80808080, then 0x7F7F7F7F.
REQ-033 Skew and backpressure: send 8 words on s0 only, then 8 on s1, with m_tready=0.
- s0_tready low after 8 pushes (FIFOD=8).
- m_tvalid holds the first sum stable.
- Release m_tready -> all 8 sums in order, one per cycle.
REQ-034 Framing error: s0 tlast=1 paired with s1 tlast=0 -> err_last_mismatch=1 after that pop, m_tlast=1, vec_count increments. The flag stays 1 until rst.
REQ-035 Reset mid-vector: 3 words buffered per input, m_tvalid=1, rst pulsed 1 cycle ->
- all outputs 0 and tready low during rst;
- no stale word emitted afterwards;
- a new pair produces its correct sum 2 edges after push.
